// File: rtl/mem_responder.sv
// Memory-side responder for the RV32I core: one request at a time, wait states,
// sized loads/stores against an internal word RAM, error responses.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t        state;
   logic [AW+1:0] addr_q;
   logic [2:0]    size_q;
   logic          we_q;
   logic [31:0]   wdata_q;
   logic [3:0]    cnt;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   ram_q;
   logic [AW-1:0] ridx;

   logic          req_err;
   logic [3:0]    be;
   logic [31:0]   wd;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_data;

   assign req_ready = (state == IDLE) && !reset;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = req_addr[0];
         3'b010:  req_err = |req_addr[1:0];
         3'b100:  req_err = req_we;
         3'b101:  req_err = req_we | req_addr[0];
         default: req_err = 1'b1;
      endcase
      if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))
         req_err = 1'b1;
   end

   always_comb begin
      be = 4'b0000;
      wd = wdata_q;
      case (size_q[1:0])
         2'b00: begin
            be[addr_q[1:0]] = 1'b1;
            wd = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be = addr_q[1] ? 4'b1100 : 4'b0011;
            wd = {2{wdata_q[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   always_comb begin
      byte_sel = ram_q[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? ram_q[31:16] : ram_q[15:0];
      case (size_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h000000, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0000, half_sel};
         default: load_data = ram_q;
      endcase
   end

   // Read address follows the live request while idle so the word is ready
   // by ACCESS even when WAIT is skipped.
   assign ridx = (state == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

   always_ff @(posedge clk) begin
      if (state == ACCESS && we_q && !reset) begin
         for (int unsigned b = 0; b < 4; b++)
            if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wd[8*b +: 8];
      end
      ram_q <= mem[ridx];
   end

   // Response data is formatted on the ACCESS->RESP edge so it is registered
   // throughout the RESP cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr[AW+1:0];
                  size_q  <= req_size;
                  we_q    <= req_we;
                  wdata_q <= req_wdata;
                  if (req_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (WAIT_CYCLES > 0) begin
                     state <= WAIT;
                     cnt   <= WAIT_LOAD;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= ACCESS;
               else             cnt   <= cnt - 4'd1;
            end
            ACCESS: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= we_q ? '0 : load_data;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a WAIT_CYCLES=1 instance,
// plus throughput and reset sequences on 0/1/15 wait-state instances.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   int unsigned sel;

   logic        rv0, rv1, rv2;
   logic        rdy0, rdy1, rdy2;
   logic        vld0, vld1, vld2;
   logic        err0, err1, err2;
   logic [31:0] rd0, rd1, rd2;

   logic        ready, rvalid, rerr;
   logic [31:0] rdata;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   assign rv0 = req_valid && (sel == 0);
   assign rv1 = req_valid && (sel == 1);
   assign rv2 = req_valid && (sel == 2);

   always_comb begin
      case (sel)
         1:       begin ready = rdy1; rvalid = vld1; rerr = err1; rdata = rd1; end
         2:       begin ready = rdy2; rvalid = vld2; rerr = err2; rdata = rd2; end
         default: begin ready = rdy0; rvalid = vld0; rerr = err0; rdata = rd0; end
      endcase
   end

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(err0));

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1));

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(15)) dut_w15 (
      .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rdy2), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(vld2), .rsp_rdata(rd2), .rsp_err(err2));

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               input logic [31:0] rd, input logic err);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.size = size;
      v.wdata = wdata; v.rd = rd; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      int t;
      int lat;
      @(negedge clk);
      t = 0;
      while (!ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({name, " ready"}, 32'(ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = ~we; req_addr = $urandom;
      req_size = 3'($urandom); req_wdata = $urandom;
      lat = 0;
      do begin
         lat++;
         @(negedge clk);
      end while (!rvalid && lat < 40);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " rdata"}, rdata, exp_rd);
      check({name, " err"}, 32'(rerr), 32'(exp_err));
      @(negedge clk);
      check({name, " pulse"}, 32'(rvalid), 32'd0);
   endtask

   task automatic tput(input int unsigned s, input int unsigned w, input logic [31:0] base);
      logic [31:0] dat [4];
      int          acc_cyc[$];
      int          rsp_cyc[$];
      int          idx;
      int          nrsp;
      logic [31:0] exp_rd;
      sel = s;
      for (int i = 0; i < 4; i++) dat[i] = $urandom;
      idx = 0;
      nrsp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = base; req_size = 3'b010; req_wdata = dat[0];
      for (int c = 0; c < 200 && nrsp < 4; c++) begin
         if (rvalid) begin
            exp_rd = (nrsp % 2 == 1) ? dat[nrsp-1] : 32'h0;
            check($sformatf("tput w%0d rsp%0d rdata", w, nrsp), rdata, exp_rd);
            check($sformatf("tput w%0d rsp%0d err", w, nrsp), 32'(rerr), 32'd0);
            rsp_cyc.push_back(c);
            nrsp++;
         end
         if (ready && req_valid) begin
            acc_cyc.push_back(c);
            idx++;
            @(posedge clk);
            #1;
            if (idx < 4) begin
               req_we    = (idx % 2 == 0);
               req_wdata = dat[idx];
            end else begin
               req_valid = 1'b0;
            end
            @(negedge clk);
         end else begin
            @(negedge clk);
         end
      end
      req_valid = 1'b0;
      check($sformatf("tput w%0d accepts", w), 32'(acc_cyc.size()), 32'd4);
      check($sformatf("tput w%0d responses", w), 32'(nrsp), 32'd4);
      for (int i = 1; i < acc_cyc.size(); i++)
         check($sformatf("tput w%0d interval%0d", w, i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(w + 3));
      if (acc_cyc.size() > 0 && rsp_cyc.size() > 0)
         check($sformatf("tput w%0d latency", w), 32'(rsp_cyc[0] - acc_cyc[0]), 32'(w + 2));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nrsp;
      sel = 0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int unsigned s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("reset ready dut%0d", s), 32'(ready), 32'd0);
         check($sformatf("reset rsp_valid dut%0d", s), 32'(rvalid), 32'd0);
         check($sformatf("reset rdata dut%0d", s), rdata, 32'd0);
         check($sformatf("reset err dut%0d", s), 32'(rerr), 32'd0);
      end
      sel = 0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("ready after reset", 32'(ready), 32'd1);

      vq.push_back(mk("sw00",    1, 32'h0000_0000, 3'b010, 32'h0102_0304, 32'h0000_0000, 0));
      vq.push_back(mk("sw10",    1, 32'h0000_0010, 3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 0));
      vq.push_back(mk("lw10",    0, 32'h0000_0010, 3'b010, 32'h0,        32'hDEAD_BEEF, 0));
      vq.push_back(mk("sw20",    1, 32'h0000_0020, 3'b010, 32'h80FF_7F01, 32'h0000_0000, 0));
      vq.push_back(mk("lb20",    0, 32'h0000_0020, 3'b000, 32'h0,        32'h0000_0001, 0));
      vq.push_back(mk("lb21",    0, 32'h0000_0021, 3'b000, 32'h0,        32'h0000_007F, 0));
      vq.push_back(mk("lb22",    0, 32'h0000_0022, 3'b000, 32'h0,        32'hFFFF_FFFF, 0));
      vq.push_back(mk("lbu23",   0, 32'h0000_0023, 3'b100, 32'h0,        32'h0000_0080, 0));
      vq.push_back(mk("lh22",    0, 32'h0000_0022, 3'b001, 32'h0,        32'hFFFF_80FF, 0));
      vq.push_back(mk("lhu22",   0, 32'h0000_0022, 3'b101, 32'h0,        32'h0000_80FF, 0));
      vq.push_back(mk("lh20",    0, 32'h0000_0020, 3'b001, 32'h0,        32'h0000_7F01, 0));
      vq.push_back(mk("sw30",    1, 32'h0000_0030, 3'b010, 32'h1122_3344, 32'h0000_0000, 0));
      vq.push_back(mk("sb31",    1, 32'h0000_0031, 3'b000, 32'h0000_00AA, 32'h0000_0000, 0));
      vq.push_back(mk("lw30a",   0, 32'h0000_0030, 3'b010, 32'h0,        32'h1122_AA44, 0));
      vq.push_back(mk("sh32",    1, 32'h0000_0032, 3'b001, 32'h0000_5566, 32'h0000_0000, 0));
      vq.push_back(mk("lw30b",   0, 32'h0000_0030, 3'b010, 32'h0,        32'h5566_AA44, 0));
      vq.push_back(mk("sb33",    1, 32'h0000_0033, 3'b000, 32'h0000_01FE, 32'h0000_0000, 0));
      vq.push_back(mk("lb33",    0, 32'h0000_0033, 3'b000, 32'h0,        32'hFFFF_FFFE, 0));
      vq.push_back(mk("lw30c",   0, 32'h0000_0030, 3'b010, 32'h0,        32'hFE66_AA44, 0));
      vq.push_back(mk("swFFC",   1, 32'h0000_0FFC, 3'b010, 32'hCAFE_F00D, 32'h0000_0000, 0));
      vq.push_back(mk("lwFFC",   0, 32'h0000_0FFC, 3'b010, 32'h0,        32'hCAFE_F00D, 0));
      vq.push_back(mk("lw06",    0, 32'h0000_0006, 3'b010, 32'h0,        32'h0000_0000, 1));
      vq.push_back(mk("lh03",    0, 32'h0000_0003, 3'b001, 32'h0,        32'h0000_0000, 1));
      vq.push_back(mk("size011", 0, 32'h0000_0010, 3'b011, 32'h0,        32'h0000_0000, 1));
      vq.push_back(mk("sbu10",   1, 32'h0000_0010, 3'b100, 32'h0000_0055, 32'h0000_0000, 1));
      vq.push_back(mk("lw1000",  0, 32'h0000_1000, 3'b010, 32'h0,        32'h0000_0000, 1));
      vq.push_back(mk("sw1000",  1, 32'h0000_1000, 3'b010, 32'h9999_9999, 32'h0000_0000, 1));
      vq.push_back(mk("swhigh",  1, 32'h8000_0010, 3'b010, 32'h7777_7777, 32'h0000_0000, 1));
      vq.push_back(mk("lhu21",   0, 32'h0000_0021, 3'b101, 32'h0,        32'h0000_0000, 1));
      vq.push_back(mk("sz110",   1, 32'h0000_0030, 3'b110, 32'hFFFF_FFFF, 32'h0000_0000, 1));
      vq.push_back(mk("sz111",   0, 32'h0000_0030, 3'b111, 32'h0,        32'h0000_0000, 1));
      vq.push_back(mk("sh33",    1, 32'h0000_0033, 3'b001, 32'h0000_1234, 32'h0000_0000, 1));
      vq.push_back(mk("rb lw10", 0, 32'h0000_0010, 3'b010, 32'h0,        32'hDEAD_BEEF, 0));
      vq.push_back(mk("rb lw00", 0, 32'h0000_0000, 3'b010, 32'h0,        32'h0102_0304, 0));
      vq.push_back(mk("rb lw30", 0, 32'h0000_0030, 3'b010, 32'h0,        32'hFE66_AA44, 0));

      sel = 0;
      for (int i = 0; i < vq.size(); i++)
         do_req(vq[i].name, vq[i].we, vq[i].addr, vq[i].size, vq[i].wdata,
                vq[i].rd, vq[i].err, vq[i].err ? 1 : 3);

      tput(0, 1, 32'h0000_0050);
      tput(1, 0, 32'h0000_0054);
      tput(2, 15, 32'h0000_0058);

      sel = 1;
      do_req("w0 sw60", 1, 32'h0000_0060, 3'b010, 32'hA5A5_0F0F, 32'h0, 0, 2);
      do_req("w0 lhu62", 0, 32'h0000_0062, 3'b101, 32'h0, 32'h0000_A5A5, 0, 2);
      do_req("w0 lw61", 0, 32'h0000_0061, 3'b010, 32'h0, 32'h0, 1, 1);
      sel = 2;
      do_req("w15 sw60", 1, 32'h0000_0060, 3'b010, 32'h0BAD_CAFE, 32'h0, 0, 17);
      do_req("w15 lb61", 0, 32'h0000_0061, 3'b000, 32'h0, 32'hFFFF_FFCA, 0, 17);

      // reset while the store is in WAIT
      sel = 0;
      do_req("sw40", 1, 32'h0000_0040, 3'b010, 32'h1234_5678, 32'h0, 0, 3);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 3'b010; req_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("wait ready low", 32'(ready), 32'd0);
      reset = 1'b1;
      #1;
      check("wait-reset ready", 32'(ready), 32'd0);
      check("wait-reset rsp_valid", 32'(rvalid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      nrsp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rvalid) nrsp++;
      end
      check("wait-reset no response", 32'(nrsp), 32'd0);
      check("wait-reset ready back", 32'(ready), 32'd1);
      do_req("lw40 after wait reset", 0, 32'h0000_0040, 3'b010, 32'h0, 32'h1234_5678, 0, 3);

      // reset held across the ACCESS exit edge
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 3'b010; req_wdata = 32'hAAAA_AAAA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      nrsp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rvalid) nrsp++;
      end
      check("access-reset no response", 32'(nrsp), 32'd0);
      do_req("lw40 after access reset", 0, 32'h0000_0040, 3'b010, 32'h0, 32'h1234_5678, 0, 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I core's load/store/fetch requests.
- Accepts one request at a time over a valid/ready handshake.
- Services the request from an internal word-organised RAM after a configurable number of wait states, then returns one response pulse.
- Handles byte/halfword/word sizing, load sign/zero extension, store byte lanes, and error responses for misaligned, out-of-range or illegal-size accesses.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words. Must be a power of 2.
- WAIT_CYCLES, 1: extra wait states inserted before the RAM access. Legal range 0..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load/fetch
- req_addr  input  32  byte address
- req_size  input  3  funct3 encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- req_wdata  input  32  store data, LSB-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  formatted load data; 0 for stores and errors
- rsp_err  output  1  error flag, qualified by rsp_valid

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. req_ready is 0 while reset is asserted. RAM contents are not reset.
- Clocking: clk is the clock; reset is asynchronous, active-high and takes priority over every edge.
- States:
  - IDLE: req_ready = 1.
  - WAIT: counting down wait states.
  - ACCESS: RAM read issued or write committed.
  - RESP: rsp_valid = 1 for exactly one cycle.
- req_ready is 1 only in IDLE. Accept occurs when req_valid & req_ready at a rising edge. On accept, latch addr, size, we and wdata; subsequent input changes are ignored until the next accept.
- Error check is evaluated at accept. err = any of:
  - size in {011, 110, 111};
  - store with size 100 or 101;
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - word index addr[31:2] >= DEPTH_WORDS.
- Transitions:
  - IDLE -> RESP if err. No RAM effect; rsp_err = 1, rsp_rdata = 0; latency 1 cycle.
  - IDLE -> WAIT if !err and WAIT_CYCLES > 0. Counter loads WAIT_CYCLES-1 and decrements to 0, then -> ACCESS.
  - IDLE -> ACCESS if !err and WAIT_CYCLES = 0.
  - ACCESS -> RESP.
  - RESP -> IDLE.
- Non-error latency: accept edge to rsp_valid high = WAIT_CYCLES + 2 cycles. Back-to-back throughput is one request per WAIT_CYCLES + 3 cycles.
- RAM: synchronous read, single port, word index addr[log2(DEPTH_WORDS)+1:2].
- Store lanes (byte enables):
  - sb: lane addr[1:0] <= wdata[7:0].
  - sh: half addr[1] <= wdata[15:0].
  - sw: all 4 lanes <= wdata.
  - Unselected lanes are unchanged. The write commits at the ACCESS-exit edge.
- Load formatting, applied in RESP from the RAM word plus latched addr/size:
  - lb/lbu: lane addr[1:0], sign- or zero-extended to 32 bits.
  - lh/lhu: half addr[1], sign- or zero-extended.
  - lw: full word.
- Store response: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- rsp_rdata and rsp_err hold their values after the pulse until the next RESP. No backpressure on the response; the requester must sample during the pulse.
- A req_valid presented during WAIT/ACCESS/RESP is not accepted (req_ready = 0) and must be held by the requester.
- Reset mid-operation: returns to IDLE with no response. A store in WAIT is discarded. A store in ACCESS commits only if reset is deasserted at the committing edge.
- WAIT_CYCLES = 0 must skip WAIT entirely. A counter value of 0 in WAIT always exits on the next edge.

Test Plan:
1. Reset, then sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> store rsp_valid at accept+3 (WAIT_CYCLES=1) with rdata 0, err 0; load rdata 0xDEADBEEF.
2. Store 0x80FF7F01 at 0x20, then lb 0x20 -> 0x00000001; lb 0x21 -> 0x0000007F; lb 0x22 -> 0xFFFFFFFF; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x22 -> 0x000080FF.
3. sb 0x31 data 0x000000AA over a word holding 0x11223344, then lw 0x30 -> 0x1122AA44. sh 0x32 data 0x5566 -> lw 0x30 -> 0x5566AA44.
4. lw 0x06, lh 0x03, size 011, sbu (we=1, size 100), lw at word index DEPTH_WORDS -> each gives rsp_valid 1 cycle after accept with err 1, rdata 0; RAM unchanged on readback.
5. Hold req_valid high continuously with alternating requests -> req_ready low outside IDLE, exactly one accept per WAIT_CYCLES + 3 cycles, no request lost or duplicated. Repeat with WAIT_CYCLES = 0 (latency 2) and 15 (latency 17).
6. Assert reset during WAIT of a sw to 0x40 (old value 0x12345678) -> no rsp_valid, req_ready returns to 1 after reset release, lw 0x40 -> 0x12345678.
